// File: rtl/load_store_unit.sv
// load_store_unit: sequences 8/16-bit loads and stores into little-endian byte accesses
// on an 8-bit data memory, with range checking and valid/ready request and response.
module load_store_unit #(
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_wide,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [15:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [7:0]        mem_writeData,
  output logic              mem_MemWrite,
  output logic              mem_MemRead,
  input  logic [7:0]        mem_readData
);
  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
  state_t            state_q, state_d;
  logic              write_q, wide_q, signed_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic [7:0]        lo_q, hi_q;
  logic [ADDR_W:0]   addr_ext, addr_hi;
  logic              range_err, accept, acc;
  logic [15:0]       result;
  // One extra bit so the top address plus one cannot wrap back into range.
  assign addr_ext  = {1'b0, req_addr};
  assign addr_hi   = addr_ext + (ADDR_W+1)'(1);
  assign range_err = (addr_ext >= (ADDR_W+1)'(MEM_DEPTH)) ||
                     (req_wide && addr_hi >= (ADDR_W+1)'(MEM_DEPTH));
  assign accept    = req_valid && state_q == IDLE;
  assign acc       = state_q == ACC0 || state_q == ACC1;
  assign result    = (err_q || write_q) ? 16'h0000 :
                     wide_q ? {hi_q, lo_q} :
                     signed_q ? {{8{lo_q[7]}}, lo_q} : {8'h00, lo_q};
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = req_valid ? (range_err ? RESP : ACC0) : IDLE;
      ACC0: state_d = wide_q ? ACC1 : RESP;
      ACC1: state_d = RESP;
      RESP: state_d = resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  assign req_ready     = state_q == IDLE;
  assign resp_valid    = state_q == RESP;
  assign resp_err      = resp_valid && err_q;
  assign resp_rdata    = resp_valid ? result : 16'h0000;
  assign mem_MemWrite  = acc && write_q;
  assign mem_MemRead   = acc && !write_q;
  assign mem_address   = state_q == ACC0 ? addr_q :
                         state_q == ACC1 ? addr_q + ADDR_W'(1) : '0;
  assign mem_writeData = !mem_MemWrite ? 8'h00 :
                         state_q == ACC0 ? wdata_q[7:0] : wdata_q[15:8];
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      wide_q   <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q  <= req_write;
        wide_q   <= req_wide;
        signed_q <= req_signed;
        err_q    <= range_err;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      if (state_q == ACC0 && !write_q) lo_q <= mem_readData;
      if (state_q == ACC1 && !write_q) hi_q <= mem_readData;
    end
  end
endmodule
